// File: rtl/demux_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : demux_scan_sequencer
// Brief    : Accepts an 8-bit word over valid/ready and scans it bit-by-bit
//            onto a 1-to-8 demux (in/e/sel), holding each channel DWELL cycles.
//            Optional macro DEMUX_SEQ_MSB_FIRST_EN reverses the scan order.
// Revision : 1.0 - initial release
// ============================================================================
module demux_scan_sequencer #(
  parameter int DWELL = 1,
  parameter int DW    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  input  logic       abort,
  output logic       in,
  output logic       e,
  output logic [2:0] sel,
  output logic       busy,
  output logic       done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

`ifdef DEMUX_SEQ_MSB_FIRST_EN
  localparam logic [2:0] SEL_FIRST = 3'd7;
  localparam logic [2:0] SEL_LAST  = 3'd0;
`else
  localparam logic [2:0] SEL_FIRST = 3'd0;
  localparam logic [2:0] SEL_LAST  = 3'd7;
`endif

  state_t        state, state_nxt;
  logic [7:0]    word, word_nxt;
  logic [DW-1:0] dwell, dwell_nxt;
  logic [2:0]    sel_nxt, sel_adv;
  logic          in_nxt, e_nxt, busy_nxt, done_nxt;
  logic          dwell_end, go_idle;

  assign ready = (state == IDLE) && !abort;

`ifdef DEMUX_SEQ_MSB_FIRST_EN
  assign sel_adv = sel - 3'd1;
`else
  assign sel_adv = sel + 3'd1;
`endif

  assign dwell_end = (dwell == DWELL_LAST);
  // Abort takes priority over a normal completion on the final dwell cycle.
  assign go_idle   = abort || (dwell_end && (sel == SEL_LAST));

  always_comb begin
    state_nxt = state;
    word_nxt  = word;
    dwell_nxt = dwell;
    sel_nxt   = sel;
    in_nxt    = in;
    e_nxt     = e;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (valid && ready) begin
          state_nxt = SCAN;
          word_nxt  = data;
          dwell_nxt = '0;
          sel_nxt   = SEL_FIRST;
          in_nxt    = data[SEL_FIRST];
          e_nxt     = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      SCAN: begin
        if (go_idle) begin
          state_nxt = IDLE;
          word_nxt  = '0;
          dwell_nxt = '0;
          sel_nxt   = '0;
          in_nxt    = 1'b0;
          e_nxt     = 1'b0;
          busy_nxt  = 1'b0;
          done_nxt  = !abort;
        end else if (dwell_end) begin
          dwell_nxt = '0;
          sel_nxt   = sel_adv;
          in_nxt    = word[sel_adv];
        end else begin
          dwell_nxt = dwell + DW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      word  <= '0;
      dwell <= '0;
      sel   <= '0;
      in    <= 1'b0;
      e     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      word  <= word_nxt;
      dwell <= dwell_nxt;
      sel   <= sel_nxt;
      in    <= in_nxt;
      e     <= e_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

endmodule
`default_nettype wire

// File: doc/demux_scan_sequencer.md
Name: demux_scan_sequencer

Overview:
- Upstream driver for the 1-to-8 demultiplexer stage.
- Accepts an 8-bit word over a valid/ready handshake.
- Scans the word out one bit per channel by driving the demux data bit (In), enable (E) and 3-bit channel select (Sel), holding each channel for a programmable dwell.
- Reports Busy while scanning and pulses Done when a word has been fully distributed.

Parameters:
- DWELL, 1: clock cycles each channel is held; legal range 1..15.
- DW, 4: width of the dwell counter; must satisfy 2^DW > DWELL.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- Data  input  8  word to distribute; bit k is destined for channel k.
- Valid  input  1  Data is valid.
- Ready  output  1  sequencer can accept a word; combinational, equal to (state==IDLE) && !Abort.
- Abort  input  1  cancels the scan in progress.
- In  output  1  registered data bit to the demux.
- E  output  1  registered demux enable.
- Sel  output  3  registered demux channel select.
- Busy  output  1  registered; 1 while in SCAN.
- Done  output  1  registered one-cycle pulse on normal scan completion.

Behaviour:
- One clock, Clk. Reset Rst_n is asynchronous and active-low.
- Reset: state=IDLE, In=0, E=0, Sel=0, Busy=0, Done=0, dwell counter=0, shift register=0. Ready reads 1 during and after reset unless Abort=1.
- States: IDLE, SCAN.
- IDLE:
  - E=0, so the demux output is all-zero.
  - Handshake occurs when Valid && Ready is sampled at a rising edge.
  - On handshake: latch Data internally; next cycle shows state=SCAN, Busy=1, E=1, Sel=0, In=Data[0], dwell=0.
  - Without a handshake, state stays IDLE.
- SCAN:
  - The dwell counter increments every cycle.
  - When dwell==DWELL-1 and Sel<7: dwell resets to 0, Sel increments by 1, In takes latched bit[Sel+1].
  - When dwell==DWELL-1 and Sel==7, the next cycle shows:
    - state=IDLE, E=0, Sel=0, In=0, Busy=0, Done=1 for exactly one cycle.
    - Ready=1 in that same cycle.
- Latency: the first channel is valid 1 cycle after the handshake. Each channel is held exactly DWELL cycles with E=1. The full scan lasts 8*DWELL cycles.
- Back-to-back transfers: a handshake in the Done cycle is legal. E reasserts on the next cycle, giving a word period of 8*DWELL+1 cycles with exactly one E=0 gap cycle.
- Data and Valid are ignored while in SCAN; the latched copy is used. Valid held high during SCAN produces no extra accept.
- Sel never wraps inside a scan; 7→0 happens only on the transition to IDLE.
- Abort in SCAN: the next cycle shows IDLE, E=0, Sel=0, In=0, Busy=0, Done=0, and the latched word is discarded.
- Abort in IDLE: forces Ready=0 and suppresses the handshake even if Valid=1. No other effect.
- Abort on the final dwell cycle of channel 7: Abort wins and Done is not pulsed.
- Reset mid-scan: all outputs immediately return to their reset values, independent of the clock.
- In, E and Sel change only together on a clock edge, never in separate cycles, so the demux never sees a glitching select while enabled.

Optional Feature:
- Macro: DEMUX_SEQ_MSB_FIRST_EN.
- Defined:
  - Scan order is reversed: Sel starts at 7 and decrements to 0.
  - In is always latched bit[Sel]; channel k still receives bit k.
  - Completion, Done and the Sel=0 return to IDLE follow the channel-0 dwell.
  - The first cycle after the handshake shows Sel=7, In=Data[7].
- Undefined: ascending order 0..7 as described in Behaviour.

Test Plan:
- Reset with Valid=1, Data=0xFF, Rst_n held low for 5 cycles -> In=0, E=0, Sel=0, Busy=0, Done=0 throughout; Ready=1; no scan starts before release.
- DWELL=1, Data=0xA5 accepted -> over 8 consecutive cycles (Sel,In) = (0,1),(1,0),(2,1),(3,0),(4,0),(5,1),(6,0),(7,1) with E=1; next cycle E=0, Done=1, Sel=0.
- DWELL=3, Data=0x01 -> Sel=0 with In=1 for 3 cycles, then each of Sel 1..7 with In=0 for 3 cycles; Done exactly 24 cycles after the first E=1 cycle.
- Back-to-back: Valid held high with 0x0F then 0xF0 -> second handshake occurs in the Done cycle; exactly one E=0 cycle between the words; the second word's bits appear correctly on Sel 0..7.
- Abort asserted on Sel=4 (DWELL=1, Data=0xFF) -> next cycle E=0, Sel=0, In=0, Busy=0, no Done pulse; Ready=1 once Abort is deasserted.
- With DEMUX_SEQ_MSB_FIRST_EN, Data=0x80, DWELL=1 -> first cycle Sel=7, In=1; then Sel=6..0 with In=0; Done follows Sel=0.
